// File: rtl/auc_res_rd_if.sv
// Result read-back stream bundle between the ECC result RAM reader and its host side.
//   master : read-back engine (drives RAM read request, output beats, status)
//   slave  : host / RAM side (drives start, curve select, RAM data, ready)
// Signals:
//   res_en, res_curve       start request and curve select
//   res_busy, res_done      transfer status
//   res_ren, res_radd       RAM read request
//   res_rdat                RAM read data
//   res_odat, res_ovld,
//   res_ordy, res_olast     output beat stream
interface auc_res_rd_if #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned ADDR  = 5,
    parameter int unsigned OWID  = 32
);
    logic             res_en;
    logic             res_curve;
    logic             res_busy;
    logic             res_done;
    logic             res_ren;
    logic [ADDR-1:0]  res_radd;
    logic [WIDTH-1:0] res_rdat;
    logic [OWID-1:0]  res_odat;
    logic             res_ovld;
    logic             res_ordy;
    logic             res_olast;

    modport master (
        input  res_en, res_curve, res_rdat, res_ordy,
        output res_busy, res_done, res_ren, res_radd, res_odat, res_ovld, res_olast
    );

    modport slave (
        output res_en, res_curve, res_rdat, res_ordy,
        input  res_busy, res_done, res_ren, res_radd, res_odat, res_ovld, res_olast
    );
endinterface

// File: rtl/auc_res_rd.sv
// Read-back engine for the ECC result RAM: on a start request it reads the X
// then Y result words from curve-dependent addresses and streams each word
// MSB-first as OWID-bit beats, flagging the final beat and pulsing done.
// Ports:
//   clk   core clock, rising edge
//   rst   asynchronous active-low reset
//   bus   auc_res_rd_if.master (start/curve in, RAM read port, beat stream, status)
module auc_res_rd #(
    parameter int unsigned     WIDTH = 256,
    parameter int unsigned     ADDR  = 5,
    parameter int unsigned     OWID  = 32,
    parameter int unsigned     RDLAT = 1,
    parameter logic [ADDR-1:0] XA0   = ADDR'(8),
    parameter logic [ADDR-1:0] YA0   = ADDR'(9),
    parameter logic [ADDR-1:0] XA1   = ADDR'(16),
    parameter logic [ADDR-1:0] YA1   = ADDR'(17)
) (
    input  logic         clk,
    input  logic         rst,
    auc_res_rd_if.master bus
);

    // Curve 1 results occupy only the low C1_BITS of the RAM word.
    localparam int unsigned C1_BITS = 192;
    localparam int unsigned BEATS0  = WIDTH / OWID;
    localparam int unsigned BEATS1  = C1_BITS / OWID;
    localparam int unsigned BW      = $clog2(BEATS0 + 1);
    localparam int unsigned LW      = $clog2(RDLAT + 1);
    localparam int unsigned C1_SHL  = WIDTH - C1_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LAT,
        S_SEND,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             cur_q, cur_d;
    logic             w_q, w_d;
    logic [LW-1:0]    lat_q, lat_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             ren_q, ren_d;
    logic [ADDR-1:0]  radd_q, radd_d;
    logic             ovld_q, ovld_d;
    logic             olast_q, olast_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        w_d     = w_q;
        lat_d   = lat_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        ren_d   = 1'b0;
        radd_d  = radd_q;
        ovld_d  = ovld_q;
        olast_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.res_en) begin
                    state_d = S_REQ;
                    cur_d   = bus.res_curve;
                    w_d     = 1'b0;
                    ren_d   = 1'b1;
                    radd_d  = bus.res_curve ? XA1 : XA0;
                    busy_d  = 1'b1;
                end
            end

            S_REQ: begin
                lat_d   = LW'(RDLAT);
                state_d = S_LAT;
            end

            S_LAT: begin
                if (lat_q == LW'(1)) begin
                    // Curve 1 data is left-aligned so the beat is always the top slice.
                    sh_d    = cur_q ? (bus.res_rdat << C1_SHL) : bus.res_rdat;
                    bcnt_d  = cur_q ? BW'(BEATS1) : BW'(BEATS0);
                    ovld_d  = 1'b1;
                    olast_d = w_q && ((cur_q ? BEATS1 : BEATS0) == 1);
                    state_d = S_SEND;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end

            S_SEND: begin
                if (ovld_q && bus.res_ordy) begin
                    sh_d   = sh_q << OWID;
                    bcnt_d = bcnt_q - BW'(1);
                    if (bcnt_q == BW'(1)) begin
                        ovld_d = 1'b0;
                        if (!w_q) begin
                            w_d     = 1'b1;
                            ren_d   = 1'b1;
                            radd_d  = cur_q ? YA1 : YA0;
                            state_d = S_REQ;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        olast_d = w_q && (bcnt_q == BW'(2));
                    end
                end else begin
                    olast_d = olast_q;
                end
            end

            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cur_q   <= 1'b0;
            w_q     <= 1'b0;
            lat_q   <= '0;
            bcnt_q  <= '0;
            sh_q    <= '0;
            ren_q   <= 1'b0;
            radd_q  <= '0;
            ovld_q  <= 1'b0;
            olast_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            w_q     <= w_d;
            lat_q   <= lat_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            ren_q   <= ren_d;
            radd_q  <= radd_d;
            ovld_q  <= ovld_d;
            olast_q <= olast_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.res_busy  = busy_q;
    assign bus.res_done  = done_q;
    assign bus.res_ren   = ren_q;
    assign bus.res_radd  = radd_q;
    assign bus.res_odat  = sh_q[WIDTH-1 -: OWID];
    assign bus.res_ovld  = ovld_q;
    assign bus.res_olast = olast_q;

endmodule
